// File: rtl/tile_scan_ctrl.sv
// tile_scan_ctrl: raster-band window scan scheduler with credit-limited issue; optional SCAN_STALL_CNT_EN adds stall_cnt[31:0]
//   in:  clk, rst, start, tile_ready, res_valid
//   out: tile_valid, tile_row[8:0], tile_col[9:0], band_first, frame_last, busy, done, proto_err
module tile_scan_ctrl #(
  parameter int IMG_W    = 638,
  parameter int IMG_H    = 482,
  parameter int WIN_ROWS = 3,
  parameter int WIN_COLS = 14,
  parameter int STEP_ROW = 3,
  parameter int STEP_COL = 12,
  parameter int MAX_OUT  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [8:0]  tile_row,
  output logic [9:0]  tile_col,
  output logic        band_first,
  output logic        frame_last,
  input  logic        res_valid,
  output logic        busy,
  output logic        done,
  output logic        proto_err
`ifdef SCAN_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam logic [8:0] ROW_LAST = 9'(((IMG_H - WIN_ROWS) / STEP_ROW) * STEP_ROW);
  localparam logic [9:0] COL_LAST = 10'(WIN_COLS - 1 + (IMG_W - WIN_COLS) % STEP_COL);
  localparam logic [9:0] COL_TOP  = 10'(IMG_W - 1);
  localparam logic [9:0] COL_MIN  = 10'(WIN_COLS - 1 + STEP_COL);
  localparam logic [9:0] COL_STEP = 10'(STEP_COL);
  localparam logic [8:0] ROW_STEP = 9'(STEP_ROW);
  localparam logic [3:0] MAX_C    = 4'(MAX_OUT);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] st_q, st_d;
  logic [8:0] row_q, row_d;
  logic [9:0] col_q, col_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d, fire, go;
  assign tile_valid = st_q == ISSUE && cnt_q < MAX_C;
  assign fire       = tile_valid & tile_ready;
  assign go         = st_q == IDLE && start;
  assign tile_row   = row_q;
  assign tile_col   = col_q;
  assign band_first = col_q == COL_TOP;
  assign frame_last = row_q == ROW_LAST && col_q == COL_LAST;
  assign busy       = st_q == ISSUE || st_q == DRAIN;
  assign done       = st_q == DONE;
  assign proto_err  = err_q;
  always_comb begin
    // a result arriving at zero credits alongside a fire is dropped; the fire still takes a credit
    cnt_d = fire && (!res_valid || cnt_q == 4'd0) ? cnt_q + 4'd1 :
            res_valid && !fire && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    err_d = err_q | (res_valid && !fire && cnt_q == 4'd0);
    row_d = go ? 9'd0 : fire && !frame_last && col_q < COL_MIN ? row_q + ROW_STEP : row_q;
    col_d = go ? COL_TOP : fire && !frame_last ? (col_q >= COL_MIN ? col_q - COL_STEP : COL_TOP) : col_q;
    st_d  = st_q == IDLE  ? (start ? ISSUE : IDLE) :
            st_q == ISSUE ? (fire && frame_last ? DRAIN : ISSUE) :
            st_q == DRAIN ? (cnt_d == 4'd0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      row_q <= 9'd0;
      col_q <= COL_TOP;
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      row_q <= row_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`ifdef SCAN_STALL_CNT_EN
  logic [31:0] stall_q;
  assign stall_cnt = stall_q;
  always_ff @(posedge clk) begin
    if (rst || go) stall_q <= 32'd0;
    else if (st_q == ISSUE && !fire && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_tile_scan_ctrl.sv
// tb_tile_scan_ctrl: randomized self-checking bench for tile_scan_ctrl against an index-based window model
module tb_tile_scan_ctrl;
  logic clk = 0;
  always #5 clk = ~clk;
  int total = 0, pass = 0;
  logic rst0 = 1, s0 = 0, rd0 = 0, rv0 = 0;
  logic v0, bf0, fl0, busy0, done0, pe0;
  logic [8:0] row0;
  logic [9:0] col0;
  logic rst1 = 1, s1 = 0, rd1 = 0, rv1 = 0;
  logic v1, bf1, fl1, busy1, done1, pe1;
  logic [8:0] row1;
  logic [9:0] col1;
  logic rst2 = 1, s2 = 0, rd2 = 0, rv2 = 0;
  logic v2, bf2, fl2, busy2, done2, pe2;
  logic [8:0] row2;
  logic [9:0] col2;
`ifdef SCAN_STALL_CNT_EN
  logic [31:0] sc0, sc1, sc2;
`endif
  tile_scan_ctrl u0 (.clk(clk), .rst(rst0), .start(s0), .tile_valid(v0), .tile_ready(rd0), .tile_row(row0),
    .tile_col(col0), .band_first(bf0), .frame_last(fl0), .res_valid(rv0), .busy(busy0), .done(done0), .proto_err(pe0)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(sc0)
`endif
  );
  tile_scan_ctrl #(.MAX_OUT(2)) u1 (.clk(clk), .rst(rst1), .start(s1), .tile_valid(v1), .tile_ready(rd1), .tile_row(row1),
    .tile_col(col1), .band_first(bf1), .frame_last(fl1), .res_valid(rv1), .busy(busy1), .done(done1), .proto_err(pe1)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );
  tile_scan_ctrl #(.IMG_W(26), .IMG_H(8)) u2 (.clk(clk), .rst(rst2), .start(s2), .tile_valid(v2), .tile_ready(rd2), .tile_row(row2),
    .tile_col(col2), .band_first(bf2), .frame_last(fl2), .res_valid(rv2), .busy(busy2), .done(done2), .proto_err(pe2)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );
  // window n of a w x h frame: 14x3 windows, 12-column steps right-to-left, 3-row bands
  function automatic void win(input int w, input int h, input int n, output int r, output int c, output bit bf, output bit fl);
    int wpb, nb;
    wpb = (w - 14) / 12 + 1;
    nb  = (h - 3) / 3 + 1;
    r   = (n / wpb) * 3;
    c   = w - 1 - (n % wpb) * 12;
    bf  = (n % wpb) == 0;
    fl  = n == wpb * nb - 1;
  endfunction
  task automatic step;
    @(negedge clk);
  endtask
  task automatic test_reset;
    total++; if (v0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", v0); else pass++;
    total++; if (busy0 !== 1'b0 || done0 !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", busy0, done0); else pass++;
    total++; if (pe0 !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", pe0); else pass++;
    total++; if (row0 !== 9'd0 || col0 !== 10'd637) $display("FAIL reset_payload: got (%0d,%0d) want (0,637)", row0, col0); else pass++;
`ifdef SCAN_STALL_CNT_EN
    total++; if (sc0 !== 32'd0) $display("FAIL reset_stall_cnt: got %0d want 0", sc0); else pass++;
`endif
  endtask
  task automatic test_scan(input bit rnd);
    int n, t, last_rv, done_t, r, c;
    bit bf, fl, f1, f2, fire, hold;
    logic [8:0] hr;
    logic [9:0] hc;
    n = 0; t = 0; last_rv = -10; done_t = -1; f1 = 0; f2 = 0; hold = 0; hr = 0; hc = 0;
    s0 = 1; step; s0 = 0;
    total++; if (busy0 !== 1'b1) $display("FAIL scan_busy_start: got %b want 1", busy0); else pass++;
    while (done_t < 0 && t < 40000) begin
      if (done0) done_t = t;
      else begin
        if (hold) begin
          total++;
          if (v0 !== 1'b1 || row0 !== hr || col0 !== hc)
            $display("FAIL scan_hold: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", v0, row0, col0, hr, hc);
          else pass++;
        end
        rd0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        rv0 = f2;
        if (f2) last_rv = t;
        s0 = rnd && t == 200;
        fire = v0 && rd0;
        if (fire) begin
          win(638, 482, n, r, c, bf, fl);
          total++;
          if (row0 !== 9'(r) || col0 !== 10'(c) || bf0 !== bf || fl0 !== fl)
            $display("FAIL scan_fire%0d: got (%0d,%0d) bf=%b fl=%b want (%0d,%0d) bf=%b fl=%b", n, row0, col0, bf0, fl0, r, c, bf, fl);
          else pass++;
          n++;
        end
        hold = v0 && !rd0; hr = row0; hc = col0;
        f2 = f1; f1 = fire;
        step; t++;
      end
    end
    rd0 = 0; rv0 = 0; s0 = 0;
    total++; if (n != 8480) $display("FAIL scan_fire_count: got %0d want 8480", n); else pass++;
    total++; if (done_t < 0 || done_t != last_rv + 1) $display("FAIL scan_done_timing: got cycle %0d want %0d", done_t, last_rv + 1); else pass++;
    total++; if (busy0 !== 1'b0) $display("FAIL scan_busy_at_done: got %b want 0", busy0); else pass++;
    step;
    total++; if (done0 !== 1'b0) $display("FAIL scan_done_pulse: got %b want 0", done0); else pass++;
  endtask
  task automatic test_reset_mid;
    int n, t;
    bit f1, f2, seen;
    n = 0; t = 0; f1 = 0; f2 = 0; seen = 0;
    s0 = 1; step; s0 = 0; rd0 = 1;
    while (n < 100 && t < 500) begin
      rv0 = f2;
      f2 = f1; f1 = v0;
      if (v0) n++;
      step; t++;
    end
    total++; if (n != 100) $display("FAIL mid_fires: got %0d want 100", n); else pass++;
    rst0 = 1; rv0 = 0; rd0 = 0; step; rst0 = 0;
    total++; if (v0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL mid_rst_state: got v=%b busy=%b want 0 0", v0, busy0); else pass++;
    total++; if (col0 !== 10'd637 || row0 !== 9'd0) $display("FAIL mid_rst_payload: got (%0d,%0d) want (0,637)", row0, col0); else pass++;
    for (int i = 0; i < 20; i++) begin
      if (done0) seen = 1;
      step;
    end
    total++; if (seen) $display("FAIL mid_rst_done: got done pulse want none"); else pass++;
  endtask
  task automatic test_credits;
    int f, r, c;
    bit bf, fl;
    f = 0;
    s1 = 1; step; s1 = 0; rd1 = 1; rv1 = 0;
    for (int i = 0; i < 8; i++) begin
      if (v1) f++;
      step;
    end
    total++; if (f != 2) $display("FAIL credit_fires: got %0d want 2", f); else pass++;
    total++; if (v1 !== 1'b0) $display("FAIL credit_block: got %b want 0", v1); else pass++;
    rd1 = 0; rv1 = 1; step; rv1 = 0;
    win(638, 482, 2, r, c, bf, fl);
    total++; if (v1 !== 1'b1 || row1 !== 9'(r) || col1 !== 10'(c)) $display("FAIL credit_return: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", v1, row1, col1, r, c); else pass++;
    rd1 = 1; rv1 = 1; step; rv1 = 0;
    win(638, 482, 3, r, c, bf, fl);
    total++; if (v1 !== 1'b1 || col1 !== 10'(c)) $display("FAIL credit_same_cycle: got v=%b col=%0d want v=1 col=%0d", v1, col1, c); else pass++;
    step;
    total++; if (v1 !== 1'b0) $display("FAIL credit_refill: got %b want 0", v1); else pass++;
    rd1 = 0; rv1 = 1; step; step; rv1 = 0;
    total++; if (v1 !== 1'b1 || pe1 !== 1'b0) $display("FAIL credit_drain: got v=%b err=%b want 1 0", v1, pe1); else pass++;
    rd1 = 1; rv1 = 1; step; rv1 = 0; step;
    total++; if (v1 !== 1'b0 || pe1 !== 1'b0) $display("FAIL zero_fire_res: got v=%b err=%b want 0 0", v1, pe1); else pass++;
    rd1 = 0; rv1 = 1; step; step; rv1 = 0;
    total++; if (pe1 !== 1'b0) $display("FAIL proto_clean: got %b want 0", pe1); else pass++;
    rv1 = 1; step; rv1 = 0;
    total++; if (pe1 !== 1'b1 || v1 !== 1'b1) $display("FAIL proto_set: got err=%b v=%b want 1 1", pe1, v1); else pass++;
    step; step; step;
    total++; if (pe1 !== 1'b1) $display("FAIL proto_sticky: got %b want 1", pe1); else pass++;
    rst1 = 1; step; rst1 = 0;
    total++; if (pe1 !== 1'b0) $display("FAIL proto_rst: got %b want 0", pe1); else pass++;
  endtask
  task automatic test_small_frame;
    int n, t, r, c;
    bit bf, fl, f1, seen;
    n = 0; t = 0; f1 = 0; seen = 0;
    s2 = 1; step; s2 = 0; rd2 = 1;
    while (!seen && t < 100) begin
      if (done2) seen = 1;
      else begin
        rv2 = f1;
        f1 = v2;
        if (v2) begin
          win(26, 8, n, r, c, bf, fl);
          total++;
          if (row2 !== 9'(r) || col2 !== 10'(c) || fl2 !== fl)
            $display("FAIL small_fire%0d: got (%0d,%0d) fl=%b want (%0d,%0d) fl=%b", n, row2, col2, fl2, r, c, fl);
          else pass++;
          n++;
        end
        step; t++;
      end
    end
    rd2 = 0; rv2 = 0;
    total++; if (!seen || n != 4) $display("FAIL small_done: got done=%b fires=%0d want 1 4", seen, n); else pass++;
  endtask
`ifdef SCAN_STALL_CNT_EN
  task automatic test_stall_cnt;
    s0 = 1; step; s0 = 0; rd0 = 0;
    repeat (7) step;
    total++; if (sc0 !== 32'd7) $display("FAIL stall_cnt: got %0d want 7", sc0); else pass++;
    rst0 = 1; step; rst0 = 0;
  endtask
`endif
  initial begin
    repeat (3) step;
    rst0 = 0; rst1 = 0; rst2 = 0;
    test_reset;
    test_scan(1'b0);
    test_scan(1'b1);
    test_reset_mid;
    test_credits;
    test_small_frame;
`ifdef SCAN_STALL_CNT_EN
    test_stall_cnt;
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
